// File: rtl/message_reader.sv
// message_reader: receive end of the character-message path.
// Bytes arrive one per IN_VALID cycle and are stored at countdown addresses
// MSG_LEN..0 of a 16-entry buffer. A zero byte terminates a message early.
// Optional build macro MSGREADER_CHECK_EN enables comparison of the received
// message against EXPECTED_DATA and drives MATCH. Without it, MATCH is tied to 0.
module message_reader #(
  parameter int DEPTH = 16
`ifdef MSGREADER_CHECK_EN
  ,
  parameter logic [7:0] EXPECTED_DATA [0:15] =
    '{0: 8'd70, 1: 8'd80, 2: 8'd71, 3: 8'd65, default: 8'd0}
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       START,
  input  logic [3:0] MSG_LEN,
  input  logic [7:0] IN,
  input  logic       IN_VALID,
  input  logic [3:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [4:0] RX_COUNT,
  output logic       MATCH
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [4:0]  rx_count;
  logic        err_r;
  logic [7:0]  mem [DEPTH];

  // START has priority, so a byte arriving with START is never accepted.
  logic accept;
  logic store;
  logic term;
  logic last;

  assign accept = (state == S_RECV) && IN_VALID && !START;
  assign store  = accept && (IN != 8'd0);
  assign term   = accept && (IN == 8'd0);
  assign last   = store && (cnt == 4'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode: START restarts from any state; RECV ends on the
  // address-0 byte or on a zero terminator.
  always_comb begin
    state_next = state;
    if (START) begin
      state_next = S_RECV;
    end else if (state == S_RECV && (last || term)) begin
      state_next = S_DONE;
    end
  end

  // Address countdown, character count and early-termination flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      rx_count <= 5'd0;
      err_r    <= 1'b0;
    end else if (START) begin
      cnt      <= MSG_LEN;
      rx_count <= 5'd0;
      err_r    <= 1'b0;
    end else if (store) begin
      rx_count <= rx_count + 5'd1;
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end else if (term) begin
      err_r <= 1'b1;
    end
  end

  // Buffer write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (store) mem[cnt] <= IN;
  end

  // Registered readback; a same-cycle write to RD_ADDR returns the old data.
  always_ff @(posedge clk) begin
    if (rst) RD_DATA <= 8'd0;
    else     RD_DATA <= mem[RD_ADDR];
  end

`ifdef MSGREADER_CHECK_EN
  logic match_flag;
  logic match_r;
  logic byte_ok;

  assign byte_ok = (IN == EXPECTED_DATA[cnt]);

  // Running compare; MATCH is resolved on the same edge that raises DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_flag <= 1'b0;
      match_r    <= 1'b0;
    end else if (START) begin
      match_flag <= 1'b1;
      match_r    <= 1'b0;
    end else if (store) begin
      if (!byte_ok) match_flag <= 1'b0;
      if (last)     match_r    <= match_flag && byte_ok;
    end else if (term) begin
      match_r <= 1'b0;
    end
  end

  assign MATCH = match_r;
`else
  assign MATCH = 1'b0;
`endif

  assign BUSY     = (state == S_RECV);
  assign DONE     = (state == S_DONE);
  assign ERR      = err_r;
  assign RX_COUNT = rx_count;

endmodule
